// File: rtl/mfe_result_reader_pkg.sv
// ---------------------------------------------------------------------------
// mfe_result_reader_pkg
//
// Shared definitions for the median-filter result reader:
//   - default address / pixel widths of the engine's result memory
//   - pixels per frame for the 128x128 image
//   - checksum width
//   - FSM state encoding used by the reader top level
// ---------------------------------------------------------------------------
package mfe_result_reader_pkg;

    localparam int AW_DEF   = 14;
    localparam int DW_DEF   = 8;
    localparam int NPIX_DEF = 128 * 128;
    localparam int CSUM_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mfe_skid_fifo2.sv
// ---------------------------------------------------------------------------
// mfe_skid_fifo2
//
// Two-entry synchronous FIFO that sits between the result-memory read
// data and the outgoing pixel stream.  The head entry is presented
// combinationally; push and pop in the same cycle are both honoured.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset, empties the FIFO
//   push       write push_data at the next edge
//   push_data  data to store
//   pop        remove the head entry at the next edge
//   head_data  oldest stored entry (zero after reset)
//   head_valid FIFO holds at least one entry
//   occupancy  number of stored entries (0..2)
// ---------------------------------------------------------------------------
module mfe_skid_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          head_valid,
    output logic [1:0]    occupancy
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_ptr_q;
    logic          wr_ptr_d;
    logic          rd_ptr_q;
    logic          rd_ptr_d;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic          pop_ok;
    logic          push_ok;

    // A pop on an empty FIFO or a push into a full one without a
    // simultaneous pop is dropped, so the pointers can never run past
    // each other even if the producer misbehaves.
    always_comb begin
        pop_ok   = pop && (count_q != 2'd0);
        push_ok  = push && ((count_q != 2'd2) || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = (count_q != 2'd0);
    assign occupancy  = count_q;

endmodule

// File: rtl/mfe_result_reader.sv
// ---------------------------------------------------------------------------
// mfe_result_reader
//
// Reads a filtered frame back out of the median-filter result memory in
// raster order and presents it as a valid/ready pixel stream, while
// keeping a running 16-bit checksum of the streamed pixels.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset (aborts a frame, no done)
//   start      one-cycle frame request, only honoured in IDLE
//   busy       frame in progress (READ or DRAIN)
//   done       one-cycle pulse after the last pixel handshake
//   addr       result-memory read address
//   ren        result-memory read enable (data_rd valid one cycle later)
//   data_rd    result-memory read data
//   pix_data   stream pixel
//   pix_valid  stream valid
//   pix_ready  stream ready from the sink
//   pix_last   marks the pixel at address NPIX-1
//   checksum   sum of streamed pixels mod 2^16, held until the next start
// ---------------------------------------------------------------------------
module mfe_result_reader
    import mfe_result_reader_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int NPIX = NPIX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     addr,
    output logic              ren,
    input  logic [DW-1:0]     data_rd,
    output logic [DW-1:0]     pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic [CSUM_W-1:0] checksum
);

    // One extra bit so the issue counter can hold NPIX itself when
    // NPIX = 2^AW.
    localparam int            CW     = AW + 1;
    localparam logic [CW-1:0] NPIX_C = CW'(NPIX);
    localparam logic [CW-1:0] LAST_C = CW'(NPIX - 1);

    state_t              state_q;
    state_t              state_d;
    logic [CW-1:0]       issue_cnt_q;
    logic [CW-1:0]       issue_cnt_d;
    logic [CW-1:0]       pop_cnt_q;
    logic [CW-1:0]       pop_cnt_d;
    logic [AW-1:0]       addr_q;
    logic [AW-1:0]       addr_d;
    logic                inflight_q;
    logic                inflight_d;
    logic [CSUM_W-1:0]   csum_q;
    logic [CSUM_W-1:0]   csum_d;

    logic [DW-1:0]       fifo_head;
    logic                fifo_valid;
    logic [1:0]          fifo_occ;
    logic                handshake;
    logic [2:0]          outstanding;

    mfe_skid_fifo2 #(
        .DW(DW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (inflight_q),
        .push_data  (data_rd),
        .pop        (handshake),
        .head_data  (fifo_head),
        .head_valid (fifo_valid),
        .occupancy  (fifo_occ)
    );

    assign handshake = fifo_valid && pix_ready;

    // Entries that will occupy the FIFO after this edge without a new
    // read.  Issuing only while this is below two means a read launched
    // now always finds a free slot two edges later, and with the sink
    // always ready the count settles at one so a read goes out every cycle.
    assign outstanding = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, handshake};

    // Read issue is combinational from the registered state so that a
    // pop this cycle can immediately open room for the next read.
    always_comb begin
        ren = (state_q == ST_READ) && (issue_cnt_q != NPIX_C) && (outstanding < 3'd2);
        addr = ren ? issue_cnt_q[AW-1:0] : addr_q;
    end

    // Next-state logic: counters, checksum and frame FSM.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        addr_d      = addr_q;
        csum_d      = csum_q;
        inflight_d  = ren;

        if (ren) begin
            issue_cnt_d = issue_cnt_q + CW'(1);
            addr_d      = issue_cnt_q[AW-1:0];
        end

        if (handshake) begin
            pop_cnt_d = pop_cnt_q + CW'(1);
            csum_d    = csum_q + CSUM_W'(fifo_head);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_READ;
                    csum_d      = '0;
                    issue_cnt_d = '0;
                    pop_cnt_d   = '0;
                end
            end
            ST_READ: begin
                if (issue_cnt_q == NPIX_C) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (handshake && (pop_cnt_q == LAST_C)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            csum_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            csum_q      <= csum_d;
        end
    end

    assign busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign pix_data  = fifo_head;
    assign pix_valid = fifo_valid;
    assign pix_last  = fifo_valid && (pop_cnt_q == LAST_C);
    assign checksum  = csum_q;

endmodule
